csr_trap_ctrl: RTL
==================

# csr_trap_ctrl

Trap sequencer that sits directly upstream of the CSR register file and drives its single read port and both write ports. It accepts ECALL/MRET requests from the execute stage, performs the machine-mode CSR side effects (mepc, mcause, mstatus), and emits a one-cycle PC redirect to fetch (mtvec on entry, mepc on return). Nothing else writes trap CSRs while this block is busy.

## Interface
- XLEN, 64, data/PC width
- CSR_AW, 3, CSR index width (1=mepc, 2=mstatus, 3=mcause, 4=mtvec)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  trap request valid
- req_ready  out  1  high only in IDLE
- req_op  in  2  01=ECALL, 10=MRET, 00/11 = no-op
- req_pc  in  XLEN  PC of trapping instruction
- req_cause  in  XLEN  mcause value for ECALL
- csr_raddr  out  CSR_AW  read index to CSR file
- csr_rdata  in  XLEN  combinational read data
- csr_waddr1/csr_wdata1/csr_wen1  out  CSR_AW/XLEN/1  write port 1
- csr_waddr2/csr_wdata2/csr_wen2  out  CSR_AW/XLEN/1  write port 2
- redir_valid  out  1  one-cycle redirect pulse, no backpressure
- redir_pc  out  XLEN  redirect target
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ENT_WR, ENT_FIN, RET_RD, RET_FIN.
- IDLE: req_ready=1; on req_valid: op=01 -> latch pc/cause, go ENT_WR; op=10 -> RET_RD; 00/11 -> consumed, stay IDLE, no CSR activity, no redirect.
- ENT_WR: wen1 mepc<=pc_q; wen2 mcause<=cause_q; raddr=mtvec, latch into tvec_q. -> ENT_FIN.
- ENT_FIN: raddr=mstatus; wen1 mstatus<=entry_upd(rdata): MPIE(7)<=MIE(3), MIE<=0, MPP(12:11)<=11; redir_valid=1, redir_pc={tvec_q[XLEN-1:2],2'b00} (direct mode only; mode bits ignored). -> IDLE.
- RET_RD: raddr=mepc, latch into epc_q. -> RET_FIN.
- RET_FIN: raddr=mstatus; wen1 mstatus<=ret_upd(rdata): MIE<=MPIE, MPIE<=1, MPP<=11; redir_valid=1, redir_pc=epc_q. -> IDLE.
- All other mstatus bits pass through unchanged; no arithmetic beyond bit masking.
- Both write ports never target the same index in one cycle; wen2 only asserted in ENT_WR.
- When a wen is low its waddr/wdata are 0.

## Timing
- Reset (reset=0): state IDLE; req_ready=1, busy=0, all wen=0, redir_valid=0, redir_pc=0, csr_raddr=0, latches cleared. Requests presented during reset are lost; upstream must hold off.
- Accept in cycle N -> CSR writes visible to reads from N+2; redir_valid in cycle N+2 for both ECALL and MRET.
- Back-to-back: next request accepted no earlier than N+3 (ready low N+1..N+2).
- Reset asserted mid-sequence: immediate return to IDLE, outputs to reset values, partial CSR writes already committed stay, no redirect.
- redir_valid is never high two consecutive cycles.

## Configuration
- CSR_TRAP_MSTATUS_EN defined: mstatus read-modify-write in ENT_FIN/RET_FIN as above.
- Undefined: ENT_FIN/RET_FIN issue no write (wen1=0), csr_raddr=0 in those states; state sequence and redirect latency unchanged.

## Structure
- Package csr_pkg: CSR index constants (CSR_MEPC=1, CSR_MSTATUS=2, CSR_MCAUSE=3, CSR_MTVEC=4), op encodings, mstatus bit positions (MIE=3, MPIE=7, MPP=12:11), state enum.
- One sub-module csr_mstatus_upd: combinational, inputs old mstatus + is_ret, output new mstatus.

## Test plan
- ECALL pc=0x8000_0100, cause=11, mtvec=0x8000_0400, mstatus=0xa_0000_1808 -> N+1 mepc=0x8000_0100, mcause=11; N+2 mstatus=0xa_0000_1880, redir_pc=0x8000_0400.
- MRET with mepc=0x8000_0104, mstatus=0xa_0000_1880 -> N+2 redir_pc=0x8000_0104, mstatus=0xa_0000_1888.
- mtvec=0x8000_0403 -> redir_pc=0x8000_0400.
- req_valid held high with op=ECALL continuously -> accepts every 3 cycles, exactly one redir pulse each.
- op=11 -> no wen, no redirect, req_ready stays 1.
- reset pulled low in ENT_WR -> busy=0 same cycle, no redirect, mepc updated only if write edge preceded reset; without CSR_TRAP_MSTATUS_EN mstatus unchanged after ECALL.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants, CSR indices and state encoding for the trap sequencer.
// Used by csr_trap_ctrl and csr_mstatus_upd.
package csr_pkg;

   localparam int CSR_MEPC    = 1;
   localparam int CSR_MSTATUS = 2;
   localparam int CSR_MCAUSE  = 3;
   localparam int CSR_MTVEC   = 4;

   localparam logic [1:0] OP_ECALL = 2'b01;
   localparam logic [1:0] OP_MRET  = 2'b10;

   localparam int MST_MIE    = 3;
   localparam int MST_MPIE   = 7;
   localparam int MST_MPP_LO = 11;
   localparam int MST_MPP_HI = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENT_WR,
      ST_ENT_FIN,
      ST_RET_RD,
      ST_RET_FIN
   } state_t;

endpackage

// File: rtl/csr_mstatus_upd.sv
// mstatus next-value logic for trap entry (MIE->MPIE) and MRET (MPIE->MIE).
// Purely combinational; MPP is always forced to machine mode.
module csr_mstatus_upd
   import csr_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] mst_old,
   input  logic            is_ret,
   output logic [XLEN-1:0] mst_new
);

   always_comb begin
      mst_new = mst_old;
      mst_new[MST_MPP_HI:MST_MPP_LO] = 2'b11;
      if (is_ret) begin
         mst_new[MST_MIE]  = mst_old[MST_MPIE];
         mst_new[MST_MPIE] = 1'b1;
      end else begin
         mst_new[MST_MPIE] = mst_old[MST_MIE];
         mst_new[MST_MIE]  = 1'b0;
      end
   end

endmodule

// File: rtl/csr_trap_ctrl.sv
// ECALL/MRET trap sequencer driving the CSR file ports and the fetch redirect.
// Define CSR_TRAP_MSTATUS_EN to enable the mstatus read-modify-write.
module csr_trap_ctrl
   import csr_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int CSR_AW = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [XLEN-1:0]   req_pc,
   input  logic [XLEN-1:0]   req_cause,
   output logic [CSR_AW-1:0] csr_raddr,
   input  logic [XLEN-1:0]   csr_rdata,
   output logic [CSR_AW-1:0] csr_waddr1,
   output logic [XLEN-1:0]   csr_wdata1,
   output logic              csr_wen1,
   output logic [CSR_AW-1:0] csr_waddr2,
   output logic [XLEN-1:0]   csr_wdata2,
   output logic              csr_wen2,
   output logic              redir_valid,
   output logic [XLEN-1:0]   redir_pc,
   output logic              busy
);

`ifdef CSR_TRAP_MSTATUS_EN
   localparam bit MST_EN = 1'b1;
`else
   localparam bit MST_EN = 1'b0;
`endif

   localparam logic [CSR_AW-1:0] A_MEPC = CSR_AW'(CSR_MEPC);
   localparam logic [CSR_AW-1:0] A_MST  = CSR_AW'(CSR_MSTATUS);
   localparam logic [CSR_AW-1:0] A_MCA  = CSR_AW'(CSR_MCAUSE);
   localparam logic [CSR_AW-1:0] A_MTV  = CSR_AW'(CSR_MTVEC);
   localparam logic [CSR_AW-1:0] A_FIN  = MST_EN ? A_MST : '0;

   state_t state_q, state_d;
   logic [XLEN-1:0] pc_q, cause_q, tvec_q, epc_q;
   logic [XLEN-1:0] mst_new;

   csr_mstatus_upd #(.XLEN(XLEN)) u_upd (
      .mst_old (csr_rdata),
      .is_ret  (state_q == ST_RET_FIN),
      .mst_new (mst_new)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         cause_q <= '0;
         tvec_q  <= '0;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && req_valid && req_op == OP_ECALL) begin
            pc_q    <= req_pc;
            cause_q <= req_cause;
         end
         if (state_q == ST_ENT_WR) tvec_q <= csr_rdata;
         if (state_q == ST_RET_RD) epc_q  <= csr_rdata;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      csr_raddr   = '0;
      csr_wen1    = 1'b0;
      csr_waddr1  = '0;
      csr_wdata1  = '0;
      csr_wen2    = 1'b0;
      csr_waddr2  = '0;
      csr_wdata2  = '0;
      redir_valid = 1'b0;
      redir_pc    = '0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               case (req_op)
                  OP_ECALL: state_d = ST_ENT_WR;
                  OP_MRET:  state_d = ST_RET_RD;
                  default:  state_d = ST_IDLE;
               endcase
            end
         end
         ST_ENT_WR: begin
            csr_wen1   = 1'b1;
            csr_waddr1 = A_MEPC;
            csr_wdata1 = pc_q;
            csr_wen2   = 1'b1;
            csr_waddr2 = A_MCA;
            csr_wdata2 = cause_q;
            csr_raddr  = A_MTV;
            state_d    = ST_ENT_FIN;
         end
         ST_ENT_FIN: begin
            csr_raddr   = A_FIN;
            csr_wen1    = MST_EN;
            csr_waddr1  = A_FIN;
            csr_wdata1  = MST_EN ? mst_new : '0;
            redir_valid = 1'b1;
            // Direct mode only: low mode bits of mtvec are dropped
            redir_pc    = {tvec_q[XLEN-1:2], 2'b00};
            state_d     = ST_IDLE;
         end
         ST_RET_RD: begin
            csr_raddr = A_MEPC;
            state_d   = ST_RET_FIN;
         end
         ST_RET_FIN: begin
            csr_raddr   = A_FIN;
            csr_wen1    = MST_EN;
            csr_waddr1  = A_FIN;
            csr_wdata1  = MST_EN ? mst_new : '0;
            redir_valid = 1'b1;
            redir_pc    = epc_q;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q != ST_IDLE);

endmodule
